// File: rtl/fp_to_fixed_conv.sv
// fp_to_fixed_conv: converts one fpu-format float (sign, 8b two's complement
// unbiased exponent, 23b mantissa with explicit leading one) into a signed
// Q(INT_W).(FRAC_W) fixed-point value with saturation.
//
// Optional feature macro: FP2FIX_BARREL_EN
//   defined   - alignment done by a single-cycle barrel shifter (latency 1)
//   undefined - alignment iterates one bit per clock (latency |k|+1)
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid,
// fix_out and ovf stay stable until out_ready is seen high; no new input
// is taken in the same cycle as the output transfer.
module fp_to_fixed_conv #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 16,
    localparam int W     = INT_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  fp_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] fix_out,
    output logic         ovf
);

    typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

    // Shift count k = E - 22 + FRAC_W; positive k means shift left.
    localparam logic signed [9:0] K_OFF = 10'(FRAC_W - 22);
    localparam logic signed [9:0] K_MAX = 10'(W);
    localparam logic signed [9:0] K_MIN = -10'sd24;

    state_t       state_q, state_d;
    logic         sign_q, sign_d;
    logic [W-1:0] mag_q, mag_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         left_q, left_d;
    logic         sticky_q, sticky_d;
    logic [W-1:0] fix_q, fix_d;
    logic         ovf_q, ovf_d;
    logic         out_valid_q, out_valid_d;

    logic signed [9:0] k;
`ifdef FP2FIX_BARREL_EN
    logic [2*W-1:0] ext;
`endif

    // Saturate or negate the aligned magnitude; returns {ovf, fix}.
    function automatic logic [W:0] make_result(input logic sgn,
                                               input logic [W-1:0] m,
                                               input logic sticky);
        logic over;
        over = sticky | (sgn ? (m[W-1] & (|m[W-2:0])) : m[W-1]);
        if (over)
            make_result = sgn ? {1'b1, 1'b1, {(W-1){1'b0}}}
                              : {1'b1, 1'b0, {(W-1){1'b1}}};
        else
            make_result = {1'b0, (sgn ? (~m + 1'b1) : m)};
    endfunction

    assign k         = signed'({{2{fp_in[30]}}, fp_in[30:23]}) + K_OFF;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign fix_out   = fix_q;
    assign ovf       = ovf_q;

    // Next-state and datapath: accept/decode, align, present result.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        sticky_d    = sticky_q;
        fix_d       = fix_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
`ifdef FP2FIX_BARREL_EN
        ext         = {{W{1'b0}}, mag_q} << cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = fp_in[31];
                    mag_d    = {{(W-23){1'b0}}, fp_in[22:0]};
                    cnt_d    = 7'(k[9] ? -k : k);
                    left_d   = !k[9] && (k != 10'sd0);
                    sticky_d = 1'b0;
                    if (fp_in[22:0] == 23'd0) begin
                        mag_d = '0;
                        cnt_d = '0;
                    end else if (k > K_MAX) begin
                        sticky_d = 1'b1;
                        cnt_d    = '0;
                    end else if (k < K_MIN) begin
                        mag_d = '0;
                        cnt_d = '0;
                    end
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
`ifdef FP2FIX_BARREL_EN
                if (left_q)
                    {ovf_d, fix_d} = make_result(sign_q, ext[W-1:0],
                                                 sticky_q | (|ext[2*W-1:W]));
                else
                    {ovf_d, fix_d} = make_result(sign_q, mag_q >> cnt_q, sticky_q);
                out_valid_d = 1'b1;
                state_d     = DONE;
`else
                if (cnt_q != 7'd0) begin
                    if (left_q) begin
                        sticky_d = sticky_q | mag_q[W-1];
                        mag_d    = mag_q << 1;
                    end else begin
                        mag_d    = mag_q >> 1;
                    end
                    cnt_d = cnt_q - 7'd1;
                end else begin
                    {ovf_d, fix_d} = make_result(sign_q, mag_q, sticky_q);
                    out_valid_d    = 1'b1;
                    state_d        = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            sticky_q    <= 1'b0;
            fix_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            sticky_q    <= sticky_d;
            fix_q       <= fix_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp_to_fixed_conv.sv
// Testbench for fp_to_fixed_conv (INT_W=16, FRAC_W=16): directed vectors,
// scoreboard queues filled by the driver, monitor pops on output transfers.
module tb_fp_to_fixed_conv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [31:0]  fp_in = 32'd0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] fix_out;
  logic         ovf;

  fp_to_fixed_conv #(.INT_W(16), .FRAC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fix_out   (fix_out),
    .ovf       (ovf)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];
  int         lat_q[$];
  int         acc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input int n);
`ifdef FP2FIX_BARREL_EN
    return (n > 0) ? 1 : 1;
`else
    return n;
`endif
  endfunction

  // directed vectors: fp_in, {ovf, fix_out}, iterative latency
  localparam int NV = 14;
  logic [31:0] v_fp [NV] = '{
    32'h01CE0000, 32'h824A4000, 32'h00000000, 32'h80000000,
    32'h0A400000, 32'h8A400000, 32'h3FC00000, 32'h40400000,
    32'h87C00000, 32'h07C00000, 32'h00600001, 32'h80600001,
    32'h777FFFFF, 32'h03400000};
  logic [W:0] v_exp [NV] = '{
    {1'b0, 32'h0009C000}, {1'b0, 32'hFFED7000}, {1'b0, 32'h00000000}, {1'b0, 32'h00000000},
    {1'b1, 32'h7FFFFFFF}, {1'b1, 32'h80000000}, {1'b1, 32'h7FFFFFFF}, {1'b0, 32'h00000000},
    {1'b0, 32'h80000000}, {1'b1, 32'h7FFFFFFF}, {1'b0, 32'h00018000}, {1'b0, 32'hFFFE8000},
    {1'b0, 32'h00000000}, {1'b0, 32'h00400000}};
  int v_lat [NV] = '{4, 3, 1, 1, 15, 15, 1, 1, 10, 10, 7, 7, 25, 1};

  // driver: wait for in_ready, transfer one operand, record expectation
  task automatic send(input logic [31:0] fp, input logic [W:0] e, input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0, expected 1");
    end
    in_valid = 1'b1;
    fp_in = fp;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (push) begin
      exp_q.push_back(e);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
  endtask

  // monitor: latency on rising out_valid, stability while held, value on transfer
  logic         seen = 1'b0;
  logic [W-1:0] held_fix;
  logic         held_ovf;
  initial begin
    logic [W:0] e;
    int lexp;
    int acc;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held_fix = fix_out;
          held_ovf = ovf;
          if (lat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got fix_out 0x%0h, expected no output", fix_out);
          end else begin
            lexp = lat_q.pop_front();
            acc = acc_q.pop_front();
            check("latency", 64'(cyc - acc), 64'(lexp));
          end
        end else begin
          check("hold_fix", 64'(fix_out), 64'(held_fix));
          check("hold_ovf", 64'(ovf), 64'(held_ovf));
        end
        if (out_ready) begin
          seen = 1'b0;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("fix_out", 64'(fix_out), 64'(e[W-1:0]));
            check("ovf", 64'(ovf), 64'(e[W]));
          end
        end
      end
    end
  end

  // main sequence
  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fix_out", 64'(fix_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      send(v_fp[i], v_exp[i], exp_lat(v_lat[i]), 1'b1);
      drain();
    end

    // back-pressure: hold result, ignore input pulses, then release
    out_ready = 1'b0;
    send(32'h00600000, {1'b0, 32'h00018000}, exp_lat(7), 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("done_in_ready", 64'(in_ready), 64'd0);
      in_valid = (i % 2 == 0);
      fp_in = 32'h01CE0000;
    end
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    send(32'h824A4000, {1'b0, 32'hFFED7000}, exp_lat(3), 1'b1);
    drain();

    // reset during ALIGN aborts the conversion
    send(32'h01CE0000, '0, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_fix_out", 64'(fix_out), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    send(32'h00600000, {1'b0, 32'h00018000}, exp_lat(7), 1'b1);
    drain();
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
